serial_rev_deser: RTL

Serial-to-parallel receiver that rebuilds a DATA_WIDTH-bit word from a 1-bit serial stream. It restores the word's bit order, so a word serialized LSB-first, or MSB-first, comes out in its natural order. It is the receive end of the team's bit-ordering and serialization path. The output side is a registered word with a valid/ready handshake. The serial side has no backpressure, so words completed while the output is stalled are dropped and flagged.

---
 rtl/serial_rev_deser.sv | 74 +++++++
 1 files changed

// File: rtl/serial_rev_deser.sv
// Serial-to-parallel receiver: rebuilds a DATA_WIDTH-bit word from a 1-bit stream in
// either bit order and presents it on a registered valid/ready output with overrun flagging.
module serial_rev_deser #(
  parameter int DATA_WIDTH = 3,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  din,
  input  logic                  din_en,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  overrun
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] partial;
  logic [CW-1:0]         pos;
  logic [DATA_WIDTH-1:0] assembled;
  logic                  last_bit;
  logic                  complete;

  // The word in progress plus the bit arriving this edge; on the last bit this is the full word.
  always_comb begin
    pos       = MSB_FIRST ? (LAST - cnt) : cnt;
    assembled = partial;
    assembled[pos] = din;
    last_bit  = (cnt == LAST);
    complete  = din_en && !clear && last_bit;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= '0;
      partial    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;

      if (clear) begin
        cnt     <= '0;
        partial <= '0;
      end else if (din_en) begin
        if (last_bit) begin
          cnt     <= '0;
          partial <= '0;
        end else begin
          cnt     <= cnt + 1'b1;
          partial <= assembled;
        end
      end

      // A completed word can only land if the output slot is free or being consumed now.
      if (complete) begin
        if (dout_valid && !dout_ready) begin
          overrun <= 1'b1;
        end else begin
          dout       <= assembled;
          dout_valid <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule
